ofm_writeback: RTL
==================

OFM_WRITEBACK -- requirements
Module: ofm_writeback

Interface
REQ-001 SHALL have parameter OFM_W, default 56, output feature-map width in pixels.
REQ-002 SHALL have parameter OFM_H, default 56, output feature-map height in pixels.
REQ-003 SHALL have parameter OFM_C, default 128, output channels; multiple of 16.
REQ-004 SHALL have parameter ADDR_W, default 32, OFM BRAM write-address width.
REQ-005 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  one-cycle pulse that clears counters and FIFO, then arms capture.
REQ-008 SHALL have port valid_in  input  16  per-PE result-valid strobes from the PE cluster.
REQ-009 SHALL have port ofm_in  input  128  16 activated channel bytes; channel k in bits [8k+7:8k].
REQ-010 SHALL have port wr_en  output  1  OFM BRAM write strobe.
REQ-011 SHALL have port wr_addr  output  ADDR_W  OFM BRAM word address.
REQ-012 SHALL have port wr_data  output  32  packed 4-channel word.
REQ-013 SHALL have port busy  output  1  high while armed and the final word is not yet written.
REQ-014 SHALL have port done  output  1  one-cycle pulse after the last word of the map is written.
REQ-015 SHALL have port overflow  output  1  sticky; a window was dropped.

Function
REQ-016 SHALL capture ofm_in into a 2-entry FIFO when armed and valid_in == 16'hFFFF; any other pattern, or any pattern while unarmed, SHALL be ignored.
REQ-017 SHALL drain with FSM IDLE -> WRITE -> IDLE: WRITE emits 4 consecutive wr_en cycles (word 0..3) per FIFO entry, then pops it.
REQ-018 SHALL pack word j as channels 4j..4j+3, channel 4j in wr_data[7:0].
REQ-019 SHALL assert the first wr_en one cycle after the capturing edge when the FIFO was empty; back-to-back entries drain with no idle cycle.
REQ-020 SHALL compute wr_addr = pixel*(OFM_C/4) + tile*4 + j; pixel counts 0..OFM_W*OFM_H-1, tile counts 0..OFM_C/16-1.
REQ-021 SHALL advance pixel after word 3; at the last pixel, wrap pixel to 0 and increment tile.
REQ-022 SHALL, after word 3 of the last pixel of the last tile, pulse done, drop busy, disarm, and return to IDLE.
REQ-023 SHALL drop a capture arriving with the FIFO full and no pop on that cycle, and SHALL set overflow.
REQ-024 SHALL accept a capture while full if a pop occurs on the same cycle, without setting overflow.
REQ-025 SHALL, on start at any time, flush the FIFO, zero the counters, clear overflow, suppress wr_en on that cycle, and ignore any capture on that cycle.
REQ-026 SHALL hold wr_addr and wr_data at their last values when wr_en is low.

Reset
REQ-027 SHALL on reset_n low clear all of the following: FSM to IDLE, FIFO empty, counters 0, unarmed.
REQ-028 SHALL on reset_n low drive these outputs low: wr_en, busy, done, overflow, wr_addr, wr_data.
REQ-029 SHALL abandon any window in progress when reset_n falls mid-operation; no further wr_en until the next start.

Structure
REQ-030 SHALL take FSM state enum, lane count 16 and bytes-per-word 4 from the shared CNN package.
REQ-031 SHALL implement the FIFO as sub-module ofm_window_fifo (depth 2, width 128).

Verification
REQ-032 SHALL cover this scenario: start, then one window with ofm_in byte k = k. Required: wr_en for 4 cycles, addrs 0,1,2,3, data 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C.
REQ-033 SHALL cover this scenario: valid_in = 16'h7FFF. Required: no write occurs and overflow stays 0.
REQ-034 SHALL cover this scenario: three windows on consecutive cycles. Required: the first two are written (8 wr_en cycles) and the third is dropped with overflow = 1.
REQ-035 SHALL cover this scenario: OFM_W = OFM_H = 2, OFM_C = 32, 8 windows spaced 5 cycles apart. Required:
- addresses 0-3, 8-11, 16-19, 24-27, then 4-7, 12-15, 20-23, 28-31;
- done pulses once after address 31.
REQ-036 SHALL cover this scenario: reset_n low during word 2. Required: all outputs are 0 and no wr_en occurs until start plus a new window.

Source files
------------

// File: rtl/ofm_writeback_pkg.sv
// ---------------------------------------------------------------------------
// ofm_writeback_pkg
// Shared CNN constants and types used by the OFM write-back path:
//   LANES            - number of PE lanes / channels per result window
//   BYTES_PER_WORD   - channel bytes packed into one OFM BRAM word
//   wb_state_e       - write-back FSM states
//   pick_word()      - selects packed word j from a 16-channel window
// ---------------------------------------------------------------------------
package ofm_writeback_pkg;

  localparam int LANES            = 16;
  localparam int BYTES_PER_WORD   = 4;
  localparam int WORDS_PER_WINDOW = LANES / BYTES_PER_WORD;
  localparam int WINDOW_W         = LANES * 8;
  localparam int WORD_W           = BYTES_PER_WORD * 8;

  typedef logic [1:0] word_idx_t;

  typedef enum logic {
    ST_IDLE,
    ST_WRITE
  } wb_state_e;

  // Word j carries channels 4j..4j+3, lowest channel in the lowest byte.
  function automatic logic [WORD_W-1:0] pick_word(input logic [WINDOW_W-1:0] win,
                                                  input word_idx_t         j);
    logic [WORD_W-1:0] w;
    w = win[31:0];
    case (j)
      2'd0: w = win[31:0];
      2'd1: w = win[63:32];
      2'd2: w = win[95:64];
      2'd3: w = win[127:96];
      default: w = win[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ofm_writeback_if.sv
// ---------------------------------------------------------------------------
// ofm_writeback_if
// Bundles the PE-cluster result bus and the OFM BRAM write port.
//   valid_in[15:0]  per-PE result-valid strobes
//   ofm_in[127:0]   16 activated channel bytes, channel k in [8k+7:8k]
//   wr_en           OFM BRAM write strobe
//   wr_addr         OFM BRAM word address
//   wr_data[31:0]   packed 4-channel word
// Modports: master = write-back block, slave = PE cluster / BRAM side.
// ---------------------------------------------------------------------------
interface ofm_writeback_if
  import ofm_writeback_pkg::*;
#(
  parameter int ADDR_W = 32
) ();

  logic [LANES-1:0]    valid_in;
  logic [WINDOW_W-1:0] ofm_in;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [WORD_W-1:0]   wr_data;

  modport master (
    input  valid_in, ofm_in,
    output wr_en, wr_addr, wr_data
  );

  modport slave (
    output valid_in, ofm_in,
    input  wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/ofm_window_fifo.sv
// ---------------------------------------------------------------------------
// ofm_window_fifo
// Small FIFO holding captured 16-channel windows until they are drained.
//   clk, reset_n  clock, asynchronous active-low reset
//   flush         synchronous clear of all entries (push ignored that cycle)
//   push          write push_data; accepted when not full, or when a pop
//                 happens on the same cycle
//   pop           discard the head entry
//   head          current head entry (valid when !empty)
//   full, empty   occupancy flags
// ---------------------------------------------------------------------------
module ofm_window_fifo
  import ofm_writeback_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = WINDOW_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: sequential state is updated with non-blocking (<=) assignments so
  // every register samples the pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked by count, so
  // stale contents are never observed and the array can map to plain flops/RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ofm_writeback.sv
// ---------------------------------------------------------------------------
// ofm_writeback
// Captures complete 16-channel result windows from the PE cluster and writes
// them to the OFM BRAM as four packed 32-bit words per window.
//   clk, reset_n  clock, asynchronous active-low reset
//   start         one-cycle pulse: flush FIFO, zero counters, arm capture
//   bus           ofm_writeback_if.master (valid_in/ofm_in in, wr_* out)
//   busy          armed and the final word of the map not yet written
//   done          one-cycle pulse after the last word of the map is written
//   overflow      sticky; a window arrived with no room and was dropped
// Address of word j: pixel*(OFM_C/4) + tile*4 + j. Pixels run fastest,
// then 16-channel tiles.
// ---------------------------------------------------------------------------
module ofm_writeback
  import ofm_writeback_pkg::*;
#(
  parameter int OFM_W  = 56,
  parameter int OFM_H  = 56,
  parameter int OFM_C  = 128,
  parameter int ADDR_W = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  ofm_writeback_if.master bus,
  output logic            busy,
  output logic            done,
  output logic            overflow
);

  localparam int PIX_N           = OFM_W * OFM_H;
  localparam int PIX_W           = (PIX_N > 1) ? $clog2(PIX_N) : 1;
  localparam int TILE_N          = OFM_C / LANES;
  localparam int TILE_W          = (TILE_N > 1) ? $clog2(TILE_N) : 1;
  localparam int WORDS_PER_PIXEL = OFM_C / BYTES_PER_WORD;

  wb_state_e           state, state_next;
  logic                emit, pop, capture, dropped;
  logic                fifo_full, fifo_empty;
  logic [WINDOW_W-1:0] head;
  logic                armed, final_q;
  word_idx_t           word_cnt;
  logic [PIX_W-1:0]    pixel;
  logic [TILE_W-1:0]   tile;
  logic                last_pixel, last_tile, last_word;
  logic [ADDR_W-1:0]   addr_next;

  // Only a full set of lane strobes forms a window; start wins over capture.
  assign capture = armed && !start && (bus.valid_in == '1);
  assign dropped = capture && fifo_full && !pop;

  ofm_window_fifo #(
    .DEPTH (2),
    .WIDTH (WINDOW_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (start),
    .push      (capture),
    .pop       (pop),
    .push_data (bus.ofm_in),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign last_pixel = (pixel == PIX_W'(PIX_N - 1));
  assign last_tile  = (tile == TILE_W'(TILE_N - 1));
  assign last_word  = emit && (word_cnt == word_idx_t'(WORDS_PER_WINDOW - 1))
                      && last_pixel && last_tile;

  assign addr_next = ADDR_W'(pixel) * ADDR_W'(WORDS_PER_PIXEL)
                   + ADDR_W'(tile) * ADDR_W'(WORDS_PER_WINDOW)
                   + ADDR_W'(word_cnt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // IDLE emits word 0 itself as soon as an entry is present, so the next
  // entry follows word 3 of the previous one without a gap.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_next = state;
    emit       = 1'b0;
    pop        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (armed && !fifo_empty) begin
          emit       = 1'b1;
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        emit = 1'b1;
        if (word_cnt == word_idx_t'(WORDS_PER_WINDOW - 1)) begin
          pop        = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (start) begin
      emit       = 1'b0;
      pop        = 1'b0;
      state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      final_q     <= 1'b0;
      word_cnt    <= '0;
      pixel       <= '0;
      tile        <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
    end else if (start) begin
      armed     <= 1'b1;
      busy      <= 1'b1;
      done      <= 1'b0;
      overflow  <= 1'b0;
      final_q   <= 1'b0;
      word_cnt  <= '0;
      pixel     <= '0;
      tile      <= '0;
      bus.wr_en <= 1'b0;
    end else begin
      bus.wr_en <= emit;
      // done and the fall of busy follow the cycle that carried the last word.
      final_q   <= last_word;
      done      <= final_q;
      if (final_q)   busy     <= 1'b0;
      if (dropped)   overflow <= 1'b1;
      if (last_word) armed    <= 1'b0;
      if (emit) begin
        bus.wr_addr <= addr_next;
        bus.wr_data <= pick_word(head, word_cnt);
        word_cnt    <= word_cnt + word_idx_t'(1);
        if (word_cnt == word_idx_t'(WORDS_PER_WINDOW - 1)) begin
          if (last_pixel) begin
            pixel <= '0;
            tile  <= last_tile ? '0 : tile + TILE_W'(1);
          end else begin
            pixel <= pixel + PIX_W'(1);
          end
        end
      end
    end
  end

endmodule
